// File: rtl/frame_sequencer_pkg.sv
// frame_sequencer_pkg: sequencer states, LUT geometry defaults and the
// enable-permutation periods shared by the frame sequencer files.
package frame_sequencer_pkg;

  localparam int PADDR    = 8;
  localparam int PDATA    = 8;
  localparam int PERM_W   = 6;
  localparam int B_PERIOD = 10;
  localparam int C_PERIOD = 20;
  localparam int G_PERIOD = 40;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LUT_LOAD,
    S_LUT_FLUSH,
    S_STREAM,
    S_DONE
  } seq_state_t;

endpackage

// File: rtl/frame_sequencer_pix_pipe_reg.sv
// pix_pipe_reg: one-stage valid/ready register carrying {eof, eol, pixel}
// from the upstream pixel port to the datapath.
module pix_pipe_reg #(
  parameter int W = 26
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid_i,
  input  logic [W-1:0] in_data_i,
  output logic         in_ready_o,
  output logic         out_valid_o,
  output logic [W-1:0] out_data_o,
  input  logic         out_ready_i
);

  logic         valid_q;
  logic [W-1:0] data_q;

  assign in_ready_o  = ~valid_q | out_ready_i;
  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (in_valid_i && in_ready_o) begin
      valid_q <= 1'b1;
      data_q  <= in_data_i;
    end else if (out_ready_i) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/frame_sequencer.sv
// frame_sequencer: loads the gamma LUT, then streams one frame with enables
// and row/frame markers. FRAME_SEQ_ENABLE_PERMUTE_EN toggles enables by count.
module frame_sequencer
  import frame_sequencer_pkg::*;
#(
  parameter int NUM_CH    = 3,
  parameter int PIX_W     = PDATA,
  parameter int LUT_DEPTH = 1 << PADDR,
  parameter int DIM_W     = 12,
  localparam int ADDR_W   = $clog2(LUT_DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    skip_lut,
  input  logic [DIM_W-1:0]        img_width,
  input  logic [DIM_W-1:0]        img_height,
  input  logic                    mode_g,
  input  logic                    mode_c,
  input  logic                    mode_b,
  input  logic                    lut_in_valid,
  output logic                    lut_in_ready,
  input  logic [PIX_W-1:0]        lut_in_data,
  output logic                    glut_write_en_n,
  output logic [ADDR_W-1:0]       glut_from,
  output logic [PIX_W-1:0]        glut_to,
  input  logic                    pix_in_valid,
  output logic                    pix_in_ready,
  input  logic [NUM_CH*PIX_W-1:0] pix_in_data,
  output logic [NUM_CH*PIX_W-1:0] color_in,
  output logic                    color_in_valid,
  input  logic                    datapath_ready,
  output logic                    g_en,
  output logic                    c_en,
  output logic                    b_en,
  output logic                    eol,
  output logic                    eof,
  output logic                    busy,
  output logic                    done
);

  localparam int PW = NUM_CH * PIX_W;

  seq_state_t state_q, state_d;

  logic [DIM_W-1:0]  w_q, h_q;
  logic [DIM_W-1:0]  col_q, col_d;
  logic [DIM_W-1:0]  row_q, row_d;
  logic              mg_q, mc_q, mb_q;
  logic [ADDR_W-1:0] lut_cnt_q;
  logic              we_n_q;
  logic [ADDR_W-1:0] from_q;
  logic [PIX_W-1:0]  to_q;
  logic              in_done_q;

  logic          start_ok;
  logic          stream;
  logic          zero_dim;
  logic          lut_acc;
  logic          lut_last;
  logic          pipe_rdy;
  logic          pix_acc;
  logic          xfer;
  logic          in_eol;
  logic          in_eof;
  logic [PW+1:0] pipe_out;

  assign start_ok = (state_q == S_IDLE) & start;
  assign stream   = (state_q == S_STREAM);
  assign zero_dim = (w_q == '0) | (h_q == '0);
  assign lut_acc  = lut_in_valid & lut_in_ready;
  assign lut_last = (lut_cnt_q == ADDR_W'(LUT_DEPTH - 1));
  assign in_eol   = (col_q == w_q - DIM_W'(1));
  assign in_eof   = in_eol & (row_q == h_q - DIM_W'(1));
  assign pix_acc  = pix_in_valid & pix_in_ready;
  assign xfer     = color_in_valid & datapath_ready;

  assign lut_in_ready = (state_q == S_LUT_LOAD);
  // in_done_q stops upstream once the eof pixel sits in the register
  assign pix_in_ready = stream & ~zero_dim & ~in_done_q & pipe_rdy;

  pix_pipe_reg #(
    .W (PW + 2)
  ) u_pipe (
    .clk         (clk),
    .reset       (reset),
    .in_valid_i  (pix_acc),
    .in_data_i   ({in_eof, in_eol, pix_in_data}),
    .in_ready_o  (pipe_rdy),
    .out_valid_o (color_in_valid),
    .out_data_o  (pipe_out),
    .out_ready_i (datapath_ready)
  );

  assign color_in = pipe_out[PW-1:0];
  assign eol      = color_in_valid & pipe_out[PW];
  assign eof      = color_in_valid & pipe_out[PW+1];

  assign glut_write_en_n = we_n_q;
  assign glut_from       = from_q;
  assign glut_to         = to_q;
  assign busy            = (state_q != S_IDLE);
  assign done            = (state_q == S_DONE);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = skip_lut ? S_STREAM : S_LUT_LOAD;
      end
      S_LUT_LOAD: begin
        if (lut_acc && lut_last) state_d = S_LUT_FLUSH;
      end
      S_LUT_FLUSH: state_d = S_STREAM;
      S_STREAM: begin
        if (zero_dim || (xfer && eof)) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (pix_acc) begin
      if (in_eol) begin
        col_d = '0;
        row_d = row_q + DIM_W'(1);
      end else begin
        col_d = col_q + DIM_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      w_q       <= '0;
      h_q       <= '0;
      col_q     <= '0;
      row_q     <= '0;
      mg_q      <= 1'b0;
      mc_q      <= 1'b0;
      mb_q      <= 1'b0;
      lut_cnt_q <= '0;
      we_n_q    <= 1'b1;
      from_q    <= '0;
      to_q      <= '0;
      in_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      we_n_q  <= ~lut_acc;
      if (lut_acc) begin
        from_q    <= lut_cnt_q;
        to_q      <= lut_in_data;
        lut_cnt_q <= lut_cnt_q + 1'b1;
      end
      if (pix_acc && in_eof) in_done_q <= 1'b1;
      if (start_ok) begin
        w_q       <= img_width;
        h_q       <= img_height;
        mg_q      <= mode_g;
        mc_q      <= mode_c;
        mb_q      <= mode_b;
        lut_cnt_q <= '0;
        col_q     <= '0;
        row_q     <= '0;
        in_done_q <= 1'b0;
      end
    end
  end

`ifdef FRAME_SEQ_ENABLE_PERMUTE_EN
  logic [PERM_W-1:0] pb_q, pc_q, pg_q;
  logic              tb_q, tc_q, tg_q;
  logic              wb, wc, wg;

  assign wb = (pb_q == PERM_W'(B_PERIOD - 1));
  assign wc = (pc_q == PERM_W'(C_PERIOD - 1));
  assign wg = (pg_q == PERM_W'(G_PERIOD - 1));

  // each enable flips when its own transfer counter wraps
  always_ff @(posedge clk) begin
    if (reset || start_ok) begin
      pb_q <= '0;
      pc_q <= '0;
      pg_q <= '0;
      tb_q <= 1'b0;
      tc_q <= 1'b0;
      tg_q <= 1'b0;
    end else if (xfer) begin
      pb_q <= wb ? '0 : pb_q + 1'b1;
      pc_q <= wc ? '0 : pc_q + 1'b1;
      pg_q <= wg ? '0 : pg_q + 1'b1;
      tb_q <= tb_q ^ wb;
      tc_q <= tc_q ^ wc;
      tg_q <= tg_q ^ wg;
    end
  end

  assign g_en = stream & (mg_q ^ tg_q);
  assign c_en = stream & (mc_q ^ tc_q);
  assign b_en = stream & (mb_q ^ tb_q);
`else
  assign g_en = stream & mg_q;
  assign c_en = stream & mc_q;
  assign b_en = stream & mb_q;
`endif

endmodule

// File: tb/tb_frame_sequencer.sv
// tb_frame_sequencer: directed checks of LUT load, frame streaming,
// backpressure, zero-size frames, mid-load reset and enable permutation.
module tb_frame_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic        skip_lut;
  logic [11:0] img_width;
  logic [11:0] img_height;
  logic        mode_g, mode_c, mode_b;
  logic        lut_in_valid;
  logic        lut_in_ready;
  logic [7:0]  lut_in_data;
  logic        glut_write_en_n;
  logic [7:0]  glut_from;
  logic [7:0]  glut_to;
  logic        pix_in_valid;
  logic        pix_in_ready;
  logic [23:0] pix_in_data;
  logic [23:0] color_in;
  logic        color_in_valid;
  logic        datapath_ready;
  logic        g_en, c_en, b_en;
  logic        eol, eof;
  logic        busy, done;

  int checks = 0;
  int errors = 0;

  frame_sequencer dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .skip_lut        (skip_lut),
    .img_width       (img_width),
    .img_height      (img_height),
    .mode_g          (mode_g),
    .mode_c          (mode_c),
    .mode_b          (mode_b),
    .lut_in_valid    (lut_in_valid),
    .lut_in_ready    (lut_in_ready),
    .lut_in_data     (lut_in_data),
    .glut_write_en_n (glut_write_en_n),
    .glut_from       (glut_from),
    .glut_to         (glut_to),
    .pix_in_valid    (pix_in_valid),
    .pix_in_ready    (pix_in_ready),
    .pix_in_data     (pix_in_data),
    .color_in        (color_in),
    .color_in_valid  (color_in_valid),
    .datapath_ready  (datapath_ready),
    .g_en            (g_en),
    .c_en            (c_en),
    .b_en            (b_en),
    .eol             (eol),
    .eof             (eof),
    .busy            (busy),
    .done            (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] pix(input int i);
    return 24'hA00000 + 24'(i);
  endfunction

  initial begin
    int good;
    logic [2:0] en_exp;

    reset = 1'b1;
    start = 1'b0;
    skip_lut = 1'b0;
    img_width = '0;
    img_height = '0;
    mode_g = 1'b0;
    mode_c = 1'b0;
    mode_b = 1'b0;
    lut_in_valid = 1'b0;
    lut_in_data = '0;
    pix_in_valid = 1'b0;
    pix_in_data = '0;
    datapath_ready = 1'b1;
    step();
    step();

    chk("rst_we_n", 64'(glut_write_en_n), 64'(1));
    chk("rst_from", 64'(glut_from), 64'(0));
    chk("rst_to", 64'(glut_to), 64'(0));
    chk("rst_flags", 64'({color_in_valid, g_en, c_en, b_en, eol, eof}), 64'(0));
    chk("rst_ctl", 64'({busy, done, lut_in_ready, pix_in_ready}), 64'(0));
    chk("rst_color", 64'(color_in), 64'(0));

    // Full LUT load, then a 4x2 frame with g=1 c=0 b=1
    reset = 1'b0;
    start = 1'b1;
    skip_lut = 1'b0;
    img_width = 12'd4;
    img_height = 12'd2;
    mode_g = 1'b1;
    mode_c = 1'b0;
    mode_b = 1'b1;
    lut_in_valid = 1'b1;
    lut_in_data = 8'd255;
    step();
    start = 1'b0;
    chk("load_busy", 64'(busy), 64'(1));
    chk("load_ready", 64'(lut_in_ready), 64'(1));
    chk("load_we_idle", 64'(glut_write_en_n), 64'(1));
    chk("load_en_off", 64'({g_en, c_en, b_en}), 64'(0));
    good = 0;
    for (int k = 0; k < 256; k++) begin
      lut_in_data = 8'(255 - k);
      step();
      if (glut_write_en_n === 1'b0 && glut_from === 8'(k) &&
          glut_to === 8'(255 - k))
        good++;
    end
    chk("load_writes", 64'(good), 64'(256));
    chk("flush_ready", 64'(lut_in_ready), 64'(0));
    chk("flush_last", 64'({glut_from, glut_to}), 64'(16'hFF00));
    lut_in_valid = 1'b0;
    step();
    chk("stream_we_n", 64'(glut_write_en_n), 64'(1));
    chk("stream_pready", 64'(pix_in_ready), 64'(1));
    chk("stream_en", 64'({g_en, c_en, b_en}), 64'(3'b101));

    for (int i = 0; i < 8; i++) begin
      pix_in_valid = 1'b1;
      pix_in_data = pix(i);
      step();
      chk($sformatf("px%0d_data", i), 64'(color_in), 64'(pix(i)));
      chk($sformatf("px%0d_mark", i), 64'({color_in_valid, eol, eof}),
          64'({1'b1, i % 4 == 3, i == 7}));
      chk($sformatf("px%0d_en", i), 64'({g_en, c_en, b_en, done}),
          64'(4'b1010));
      if (i == 1) begin
        datapath_ready = 1'b0;
        pix_in_data = pix(2);
        #1;
        chk("stall_pready", 64'(pix_in_ready), 64'(0));
        for (int s = 0; s < 3; s++) begin
          step();
          chk($sformatf("stall%0d_hold", s),
              64'({color_in_valid, eol, eof, color_in}),
              64'({3'b100, pix(1)}));
        end
        datapath_ready = 1'b1;
      end
    end
    chk("eof_pready", 64'(pix_in_ready), 64'(0));
    pix_in_valid = 1'b0;
    step();
    chk("frame_done", 64'({done, busy, color_in_valid, eof}), 64'(4'b1100));
    step();
    chk("frame_idle", 64'({done, busy}), 64'(0));

    // skip_lut with a 0x5 frame
    start = 1'b1;
    skip_lut = 1'b1;
    img_width = 12'd0;
    img_height = 12'd5;
    pix_in_valid = 1'b1;
    pix_in_data = pix(99);
    step();
    start = 1'b0;
    chk("zero_stream", 64'({busy, done, pix_in_ready, lut_in_ready}),
        64'(4'b1000));
    step();
    chk("zero_done", 64'({done, glut_write_en_n, color_in_valid}),
        64'(3'b110));
    pix_in_valid = 1'b0;
    step();
    chk("zero_idle", 64'({done, busy}), 64'(0));

    // Reset in the middle of a load, then a fresh full load and 1x1 frame
    start = 1'b1;
    skip_lut = 1'b0;
    img_width = 12'd1;
    img_height = 12'd1;
    mode_g = 1'b1;
    mode_c = 1'b1;
    mode_b = 1'b0;
    lut_in_valid = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 100; k++) begin
      lut_in_data = 8'(k);
      step();
    end
    chk("pre_rst_from", 64'(glut_from), 64'(99));
    reset = 1'b1;
    lut_in_data = 8'd100;
    step();
    reset = 1'b0;
    chk("midrst_state", 64'({busy, glut_write_en_n, lut_in_ready}),
        64'(3'b010));
    chk("midrst_from", 64'(glut_from), 64'(0));
    start = 1'b1;
    step();
    start = 1'b0;
    good = 0;
    for (int k = 0; k < 256; k++) begin
      lut_in_data = 8'(k) ^ 8'h5A;
      step();
      if (glut_write_en_n === 1'b0 && glut_from === 8'(k) &&
          glut_to === (8'(k) ^ 8'h5A))
        good++;
    end
    chk("reload_writes", 64'(good), 64'(256));
    lut_in_valid = 1'b0;
    step();
    chk("reload_stream", 64'({busy, pix_in_ready, g_en, c_en, b_en}),
        64'(5'b11110));
    pix_in_valid = 1'b1;
    pix_in_data = pix(7);
    step();
    pix_in_valid = 1'b0;
    chk("one_px", 64'({color_in_valid, eol, eof, color_in}),
        64'({3'b111, pix(7)}));
    step();
    chk("one_done", 64'(done), 64'(1));
    step();

    // 40x1 frame with all modes off
    start = 1'b1;
    skip_lut = 1'b1;
    img_width = 12'd40;
    img_height = 12'd1;
    mode_g = 1'b0;
    mode_c = 1'b0;
    mode_b = 1'b0;
    step();
    start = 1'b0;
    pix_in_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      pix_in_data = pix(i + 100);
`ifdef FRAME_SEQ_ENABLE_PERMUTE_EN
      en_exp = {1'b0, ((i / 20) % 2) == 1, ((i / 10) % 2) == 1};
`else
      en_exp = 3'b000;
`endif
      chk($sformatf("w40_rdy%0d", i), 64'(pix_in_ready), 64'(1));
      step();
      chk($sformatf("w40_px%0d", i), 64'({eol, eof, color_in}),
          64'({i == 39, i == 39, pix(i + 100)}));
      chk($sformatf("w40_en%0d", i), 64'({g_en, c_en, b_en}), 64'(en_exp));
    end
    pix_in_valid = 1'b0;
    step();
    chk("w40_done", 64'({done, color_in_valid}), 64'(2'b10));
    step();
    chk("w40_idle", 64'(busy), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/frame_sequencer.md
# frame_sequencer

Synthesizable, parametrised sequencer that sits in front of NUM_CH datapath_channel instances. It loads the shared gamma LUT from an entry stream, then streams one frame of NUM_CH-channel pixels with valid/ready flow control. During the frame it drives the gamma/contrast/brightness enables and emits row and frame markers. It replaces the bench-only LUT-push and frame-push logic with a reusable RTL block.

## Interface
- NUM_CH, 3, channels per pixel (colour components)
- PIX_W, 8, bits per channel
- LUT_DEPTH, 256, gamma LUT entries; ADDR_W = $clog2(LUT_DEPTH)
- DIM_W, 12, width of the image-dimension inputs and counters
- clk  in  1  single clock; all logic is on the rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to run a frame; sampled only in IDLE
- skip_lut  in  1  sampled with start; 1 bypasses LUT load
- img_width, img_height  in  DIM_W each  frame size; latched on start
- mode_g, mode_c, mode_b  in  1 each  requested enables; latched on start
- lut_in_valid / lut_in_ready  in / out  1  handshake for LUT entries
- lut_in_data  in  PIX_W  LUT output value for the next address
- glut_write_en_n  out  1  active-low LUT write strobe (broadcast)
- glut_from  out  ADDR_W  LUT write address
- glut_to  out  PIX_W  LUT write data
- pix_in_valid / pix_in_ready  in / out  1  upstream pixel handshake
- pix_in_data  in  NUM_CH*PIX_W  upstream pixel; channel 0 is in the LSBs
- color_in  out  NUM_CH*PIX_W  pixel to the datapath
- color_in_valid  out  1  color_in holds a valid pixel
- datapath_ready  in  1  the datapath accepts color_in this cycle
- g_en, c_en, b_en  out  1 each  stage enables
- eol, eof  out  1 each  qualify color_in: last pixel of row / of frame
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at frame end

## Operation
- States: IDLE, LUT_LOAD, LUT_FLUSH, STREAM, DONE.
- Reset values: state IDLE; glut_write_en_n=1; glut_from=0; glut_to=0. color_in_valid, g/c/b_en, eol, eof, busy, done, lut_in_ready and pix_in_ready are all 0; color_in=0.
- IDLE→LUT_LOAD on start & ~skip_lut. IDLE→STREAM on start & skip_lut. start is ignored in any other state.
- LUT_LOAD:
  - lut_in_ready=1.
  - Each accepted entry k (k = 0..LUT_DEPTH-1, ascending) produces glut_write_en_n=0, glut_from=k, glut_to=data on the next cycle.
  - Idle cycles give glut_write_en_n=1.
  - The state moves to LUT_FLUSH after entry LUT_DEPTH-1 is accepted.
- LUT_FLUSH: presents the final write, lasts 1 cycle, then goes to STREAM.
- Enables are 0 in IDLE, LUT_LOAD and LUT_FLUSH. In STREAM they take the latched mode bits, except as noted under Configuration.
- STREAM:
  - One-stage valid/ready output register; pix_in_ready = ~color_in_valid | datapath_ready.
  - A transfer is color_in_valid & datapath_ready.
  - The column and row counters advance on each transfer and wrap the column at img_width-1.
  - eol = (col == img_width-1); eof = eol & (row == img_height-1).
  - The eof transfer clears pix_in_ready and moves the state to DONE.
- Zero dimension (img_width==0 or img_height==0): STREAM goes straight to DONE with no pixels and pix_in_ready stays 0.
- DONE: done=1 for 1 cycle, then IDLE.
- Stall: while datapath_ready=0, color_in, eol, eof and color_in_valid hold.
- Reset mid-frame or mid-load: back to IDLE on the next edge. The partial LUT load is abandoned and the pending pixel is dropped.

## Timing
- A start sampled at edge t makes lut_in_ready=1 from t+1.
- LUT write latency is 1 cycle from acceptance.
- A full LUT with lut_in_valid held high takes LUT_DEPTH+1 cycles (LUT_LOAD + LUT_FLUSH).
- Pixel latency is 1 cycle from pix_in acceptance to color_in_valid. Throughput is 1 pixel/cycle when datapath_ready=1.
- done rises the cycle after the eof transfer.

## Configuration
- FRAME_SEQ_ENABLE_PERMUTE_EN defined: in STREAM the enables start from the latched mode bits and toggle on transfer counts:
  - b_en toggles every 10 transfers.
  - c_en toggles every 20 transfers.
  - g_en toggles every 40 transfers.
  - This mode is for datapath coverage.
- Not defined: the enables are constant at the latched mode bits for the whole frame. The permutation counter is not built.

## Structure
- Package pkg holds the seq_state_t enum and the toggle-period constants (10/20/40). It reuses PADDR/PDATA for the LUT address and data.
- Sub-module pix_pipe_reg: the one-stage valid/ready register carrying {eof, eol, pixel}.

## Test plan
- Full load: start, skip_lut=0, lut_in_data=255-k with valid held high → 256 writes with glut_from 0..255 and glut_to 255..0, then LUT_FLUSH, then STREAM at cycle 258.
- Stream 4x2 with datapath_ready=1 and modes g=1,c=0,b=1 → 8 transfers; eol on transfers 4 and 8, eof on 8; done 1 cycle later; enables 1/0/1 throughout.
- Backpressure: datapath_ready=0 for 3 cycles mid-row → color_in held, no pixel lost or duplicated, counts unchanged.
- skip_lut=1 with a 0x5 frame → no glut writes, no pixels, done 2 cycles after start.
- reset asserted at LUT entry 100 → IDLE next cycle, glut_write_en_n=1, busy=0; a new start performs a full 256-entry load.
- Macro defined, 40x1 frame, modes all 0 → b_en is 1 for transfers 10-19 and 30-39; c_en is 1 for 20-39; g_en stays 0.
